// File: rtl/arb_pkg.sv
// Shared definitions for the attribute-register write arbiter: default sizing,
// the attribute-bank address bit and the write-owner encoding.
package arb_pkg;

    localparam int NREQ_DEFAULT       = 3;
    localparam int STARVE_MAX_DEFAULT = 4;
    localparam int ATTR_BANK_BIT      = 11;
    localparam int ADDR_W             = 12;
    localparam int DATA_W             = 32;

    typedef enum logic [1:0] {
        OWN_NONE = 2'd0,
        OWN_AVL  = 2'd1,
        OWN_HW   = 2'd2
    } owner_t;

endpackage

// File: rtl/rr_pick.sv
// Round-robin picker: finds the first set request after the last granted index,
// wrapping modulo NREQ. Purely combinational.
module rr_pick
    import arb_pkg::*;
#(
    parameter int NREQ = NREQ_DEFAULT,
    parameter int IDXW = (NREQ > 1) ? $clog2(NREQ) : 1
) (
    input  logic [NREQ-1:0] req_i,
    input  logic [IDXW-1:0] last_i,
    output logic [NREQ-1:0] gnt_o,
    output logic [IDXW-1:0] idx_o
);

    logic            found;
    logic [IDXW-1:0] cand;

    always_comb begin
        // NOTE: every variable gets a default before the search, so no path can infer a latch.
        gnt_o = '0;
        idx_o = '0;
        found = 1'b0;
        cand  = '0;
        for (int i = 1; i <= NREQ; i++) begin
            cand = IDXW'((int'(last_i) + i) % NREQ);
            if (!found && req_i[cand]) begin
                found       = 1'b1;
                gnt_o[cand] = 1'b1;
                idx_o       = cand;
            end
        end
    end

endmodule

// File: rtl/attr_reg_arbiter.sv
// Arbitrates attribute-bank writes between the Avalon slave port and NREQ hardware
// requesters, with a starvation limit on Avalon and a registered write port.
module attr_reg_arbiter
    import arb_pkg::*;
#(
    parameter int NREQ       = NREQ_DEFAULT,
    parameter int STARVE_MAX = STARVE_MAX_DEFAULT
) (
    input  logic                         CLK,
    input  logic                         RESET,
    input  logic                         AVL_CS,
    input  logic                         AVL_WRITE,
    input  logic [ADDR_W-1:0]            AVL_ADDR,
    input  logic [DATA_W-1:0]            AVL_WRITEDATA,
    output logic                         AVL_WAITREQUEST,
    input  logic [NREQ-1:0]              hw_req,
    input  logic [NREQ-1:0][ADDR_W-1:0]  hw_addr,
    input  logic [NREQ-1:0][DATA_W-1:0]  hw_data,
    output logic [NREQ-1:0]              hw_gnt,
    output logic                         reg_we,
    output logic [ADDR_W-1:0]            reg_addr,
    output logic [DATA_W-1:0]            reg_wdata,
    output logic [1:0]                   owner,
    output logic                         err_sticky
);

    localparam int IDXW = (NREQ > 1) ? $clog2(NREQ) : 1;

    logic              avl_valid, any_hw, hw_win, avl_win;
    logic [NREQ-1:0]   pick_gnt;
    logic [IDXW-1:0]   pick_idx;
    logic [ADDR_W-1:0] sel_addr;
    logic [DATA_W-1:0] sel_data;

    logic [2:0]        starve_q, starve_d;
    logic [IDXW-1:0]   last_hw_q, last_hw_d;
    logic              reg_we_q, reg_we_d;
    logic [ADDR_W-1:0] reg_addr_q, reg_addr_d;
    logic [DATA_W-1:0] reg_wdata_q, reg_wdata_d;
    owner_t            owner_q, owner_d;
    logic              err_q, err_d;

    rr_pick #(.NREQ(NREQ), .IDXW(IDXW)) u_rr_pick (
        .req_i  (hw_req),
        .last_i (last_hw_q),
        .gnt_o  (pick_gnt),
        .idx_o  (pick_idx)
    );

    // Grants are gated by RESET so nothing is accepted while reset is held.
    always_comb begin
        avl_valid       = AVL_CS & AVL_WRITE & AVL_ADDR[ATTR_BANK_BIT];
        any_hw          = |hw_req;
        hw_win          = RESET & any_hw & (~avl_valid | (starve_q == 3'(STARVE_MAX)));
        avl_win         = RESET & avl_valid & ~hw_win;
        hw_gnt          = hw_win ? pick_gnt : '0;
        AVL_WAITREQUEST = RESET & avl_valid & ~avl_win;

        sel_addr = '0;
        sel_data = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (pick_gnt[i]) begin
                sel_addr = sel_addr | hw_addr[i];
                sel_data = sel_data | hw_data[i];
            end
        end
    end

    always_comb begin
        starve_d    = starve_q;
        last_hw_d   = last_hw_q;
        reg_we_d    = 1'b0;
        reg_addr_d  = reg_addr_q;
        reg_wdata_d = reg_wdata_q;
        owner_d     = OWN_NONE;
        err_d       = err_q;

        if (!any_hw || hw_win) begin
            starve_d = '0;
        end else if (avl_win && starve_q != 3'(STARVE_MAX)) begin
            starve_d = starve_q + 3'd1;
        end

        if (avl_win) begin
            reg_we_d    = 1'b1;
            reg_addr_d  = AVL_ADDR;
            reg_wdata_d = AVL_WRITEDATA;
            owner_d     = OWN_AVL;
        end else if (hw_win) begin
            last_hw_d = pick_idx;
            // A misdirected hardware write is consumed but never reaches the bank.
            if (sel_addr[ATTR_BANK_BIT]) begin
                reg_we_d    = 1'b1;
                reg_addr_d  = sel_addr;
                reg_wdata_d = sel_data;
                owner_d     = OWN_HW;
            end else begin
                err_d = 1'b1;
            end
        end
    end

    always_ff @(posedge CLK or negedge RESET) begin
        // NOTE: state is updated with non-blocking assignments so every register sees pre-edge values.
        if (!RESET) begin
            starve_q    <= '0;
            last_hw_q   <= IDXW'(NREQ - 1);
            reg_we_q    <= 1'b0;
            reg_addr_q  <= '0;
            reg_wdata_q <= '0;
            owner_q     <= OWN_NONE;
            err_q       <= 1'b0;
        end else begin
            starve_q    <= starve_d;
            last_hw_q   <= last_hw_d;
            reg_we_q    <= reg_we_d;
            reg_addr_q  <= reg_addr_d;
            reg_wdata_q <= reg_wdata_d;
            owner_q     <= owner_d;
            err_q       <= err_d;
        end
    end

    assign reg_we     = reg_we_q;
    assign reg_addr   = reg_addr_q;
    assign reg_wdata  = reg_wdata_q;
    assign owner      = owner_q;
    assign err_sticky = err_q;

endmodule

// File: tb/tb_attr_reg_arbiter.sv
// Self-checking bench for attr_reg_arbiter: directed scenarios followed by random
// traffic, all compared against a behavioural model of the arbitration rules.
module tb_attr_reg_arbiter;
    import arb_pkg::*;

    localparam int NREQ       = 3;
    localparam int STARVE_MAX = 4;

    logic                        CLK = 1'b0;
    logic                        RESET = 1'b0;
    logic                        AVL_CS, AVL_WRITE;
    logic [11:0]                 AVL_ADDR;
    logic [31:0]                 AVL_WRITEDATA;
    logic                        AVL_WAITREQUEST;
    logic [NREQ-1:0]             hw_req;
    logic [NREQ-1:0][11:0]       hw_addr;
    logic [NREQ-1:0][31:0]       hw_data;
    logic [NREQ-1:0]             hw_gnt;
    logic                        reg_we;
    logic [11:0]                 reg_addr;
    logic [31:0]                 reg_wdata;
    logic [1:0]                  owner;
    logic                        err_sticky;

    attr_reg_arbiter #(.NREQ(NREQ), .STARVE_MAX(STARVE_MAX)) dut (
        .CLK             (CLK),
        .RESET           (RESET),
        .AVL_CS          (AVL_CS),
        .AVL_WRITE       (AVL_WRITE),
        .AVL_ADDR        (AVL_ADDR),
        .AVL_WRITEDATA   (AVL_WRITEDATA),
        .AVL_WAITREQUEST (AVL_WAITREQUEST),
        .hw_req          (hw_req),
        .hw_addr         (hw_addr),
        .hw_data         (hw_data),
        .hw_gnt          (hw_gnt),
        .reg_we          (reg_we),
        .reg_addr        (reg_addr),
        .reg_wdata       (reg_wdata),
        .owner           (owner),
        .err_sticky      (err_sticky)
    );

    always #5 CLK = ~CLK;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model state
    int          m_starve;
    int          m_last;
    logic        m_we;
    logic [11:0] m_addr;
    logic [31:0] m_data;
    logic [1:0]  m_owner;
    logic        m_err;
    // Decision for the cycle currently being driven
    logic        e_hw_turn;
    logic        e_avl;
    int          e_hw_idx;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=0x%0h exp=0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_starve = 0;
        m_last   = NREQ - 1;
        m_we     = 1'b0;
        m_addr   = '0;
        m_data   = '0;
        m_owner  = 2'd0;
        m_err    = 1'b0;
    endtask

    task automatic idle_inputs();
        AVL_CS        = 1'b0;
        AVL_WRITE     = 1'b0;
        AVL_ADDR      = '0;
        AVL_WRITEDATA = '0;
        hw_req        = '0;
    endtask

    // Called after the negedge once inputs are set: predicts and checks the grant outputs.
    task automatic settle();
        logic            avl_v;
        logic            any_req;
        logic [NREQ-1:0] eg;
        #2;
        avl_v     = AVL_CS && AVL_WRITE && AVL_ADDR[11];
        any_req   = (hw_req != '0);
        e_hw_turn = any_req && (!avl_v || m_starve == STARVE_MAX);
        e_avl     = avl_v && !e_hw_turn;
        e_hw_idx  = -1;
        if (e_hw_turn) begin
            for (int k = 1; k <= NREQ; k++) begin
                int j;
                j = (m_last + k) % NREQ;
                if (e_hw_idx < 0 && hw_req[j]) e_hw_idx = j;
            end
        end
        eg = '0;
        if (e_hw_idx >= 0) eg[e_hw_idx] = 1'b1;
        check("hw_gnt", 32'(hw_gnt), 32'(eg));
        check("waitreq", 32'(AVL_WAITREQUEST), 32'(avl_v && e_hw_turn));
    endtask

    // Clocks the DUT, advances the model and checks the registered write port.
    task automatic clock();
        @(posedge CLK);
        m_we    = 1'b0;
        m_owner = 2'd0;
        if (e_hw_turn) begin
            m_starve = 0;
            m_last   = e_hw_idx;
            if (hw_addr[e_hw_idx][11]) begin
                m_we    = 1'b1;
                m_addr  = hw_addr[e_hw_idx];
                m_data  = hw_data[e_hw_idx];
                m_owner = 2'd2;
            end else begin
                m_err = 1'b1;
            end
        end else if (e_avl) begin
            if (hw_req != '0 && m_starve < STARVE_MAX) m_starve++;
            m_we    = 1'b1;
            m_addr  = AVL_ADDR;
            m_data  = AVL_WRITEDATA;
            m_owner = 2'd1;
        end
        if (hw_req == '0) m_starve = 0;
        #1;
        check("reg_we", 32'(reg_we), 32'(m_we));
        check("reg_addr", 32'(reg_addr), 32'(m_addr));
        check("reg_wdata", reg_wdata, m_data);
        check("owner", 32'(owner), 32'(m_owner));
        check("err_sticky", 32'(err_sticky), 32'(m_err));
        @(negedge CLK);
    endtask

    task automatic cycle();
        settle();
        clock();
    endtask

    task automatic do_reset();
        RESET = 1'b0;
        model_reset();
        @(posedge CLK);
        @(negedge CLK);
        RESET = 1'b1;
    endtask

    initial begin
        idle_inputs();
        for (int i = 0; i < NREQ; i++) begin
            hw_addr[i] = 12'h800 | 12'(i * 16);
            hw_data[i] = 32'hA000_0000 | 32'(i);
        end
        model_reset();

        // Reset: outputs cleared and grants suppressed even with live requests
        AVL_CS = 1'b1; AVL_WRITE = 1'b1; AVL_ADDR = 12'h900; hw_req = 3'b111;
        #12;
        check("rst_gnt", 32'(hw_gnt), 32'd0);
        check("rst_wait", 32'(AVL_WAITREQUEST), 32'd0);
        check("rst_we", 32'(reg_we), 32'd0);
        check("rst_owner", 32'(owner), 32'd0);
        check("rst_err", 32'(err_sticky), 32'd0);
        check("rst_addr", 32'(reg_addr), 32'd0);
        @(negedge CLK);
        idle_inputs();
        RESET = 1'b1;

        // Single Avalon write
        AVL_CS = 1'b1; AVL_WRITE = 1'b1; AVL_ADDR = 12'h808; AVL_WRITEDATA = 32'hDEADBEEF;
        settle();
        check("avl_wait", 32'(AVL_WAITREQUEST), 32'd0);
        clock();
        check("avl_we", 32'(reg_we), 32'd1);
        check("avl_addr", 32'(reg_addr), 32'h808);
        check("avl_data", reg_wdata, 32'hDEADBEEF);
        check("avl_owner", 32'(owner), 32'd1);
        idle_inputs();
        cycle();

        // Round robin: prime last_hw = 0, then all three requesting
        hw_req = 3'b001;
        cycle();
        hw_req = 3'b111;
        for (int n = 0; n < 4; n++) begin
            logic [2:0] exp_order [4];
            exp_order = '{3'b010, 3'b100, 3'b001, 3'b010};
            settle();
            check("rr_order", 32'(hw_gnt), 32'(exp_order[n]));
            clock();
            check("rr_we", 32'(reg_we), 32'd1);
        end
        idle_inputs();
        cycle();

        // Starvation limit: four Avalon grants then one hardware grant
        AVL_CS = 1'b1; AVL_WRITE = 1'b1; AVL_ADDR = 12'h8F0; hw_req = 3'b001;
        for (int n = 0; n < 6; n++) begin
            AVL_WRITEDATA = 32'h1000 + 32'(n);
            settle();
            if (n < 4) begin
                check("stv_avl_gnt", 32'(hw_gnt), 32'd0);
                check("stv_avl_wait", 32'(AVL_WAITREQUEST), 32'd0);
            end else if (n == 4) begin
                check("stv_hw_gnt", 32'(hw_gnt), 32'b001);
                check("stv_hw_wait", 32'(AVL_WAITREQUEST), 32'd1);
            end else begin
                check("stv_resume", 32'(AVL_WAITREQUEST), 32'd0);
            end
            clock();
            if (n == 4) hw_req = 3'b000;
        end
        idle_inputs();
        cycle();

        // Misdirected hardware write: granted, no write, sticky error
        hw_req = 3'b100; hw_addr[2] = 12'h010;
        settle();
        check("bad_gnt", 32'(hw_gnt), 32'b100);
        clock();
        check("bad_we", 32'(reg_we), 32'd0);
        check("bad_err", 32'(err_sticky), 32'd1);
        hw_req = '0; hw_addr[2] = 12'h820;
        cycle();
        cycle();
        check("err_hold", 32'(err_sticky), 32'd1);

        // Avalon outside the attribute bank never stalls
        AVL_CS = 1'b1; AVL_WRITE = 1'b1; AVL_ADDR = 12'h100; AVL_WRITEDATA = 32'h5555;
        hw_req = 3'b010; hw_addr[1] = 12'h8AA;
        settle();
        check("nb_wait", 32'(AVL_WAITREQUEST), 32'd0);
        check("nb_gnt", 32'(hw_gnt), 32'b010);
        clock();
        idle_inputs();

        // Reset mid-burst
        hw_req = 3'b111;
        cycle();
        #1 RESET = 1'b0;
        model_reset();
        #1;
        check("mid_we", 32'(reg_we), 32'd0);
        check("mid_owner", 32'(owner), 32'd0);
        check("mid_err", 32'(err_sticky), 32'd0);
        check("mid_gnt", 32'(hw_gnt), 32'd0);
        @(posedge CLK);
        @(negedge CLK);
        RESET = 1'b1;
        settle();
        check("mid_first", 32'(hw_gnt), 32'b001);
        clock();
        idle_inputs();

        // Random traffic against the model
        for (int n = 0; n < 400; n++) begin
            AVL_CS        = ($urandom_range(0, 3) != 0);
            AVL_WRITE     = ($urandom_range(0, 4) != 0);
            AVL_ADDR      = 12'($urandom);
            if ($urandom_range(0, 4) != 0) AVL_ADDR[11] = 1'b1;
            AVL_WRITEDATA = $urandom;
            for (int i = 0; i < NREQ; i++) begin
                if (!hw_req[i] && $urandom_range(0, 2) == 0) begin
                    hw_req[i]  = 1'b1;
                    hw_addr[i] = 12'h800 | 12'($urandom);
                    hw_data[i] = $urandom;
                end else if (hw_req[i] && $urandom_range(0, 15) == 0) begin
                    hw_req[i] = 1'b0;
                end
            end
            cycle();
            if (e_hw_idx >= 0) hw_req[e_hw_idx] = 1'b0;
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/attr_reg_arbiter.md
ATTR_REG_ARBITER -- requirements
Module: attr_reg_arbiter

Interface
REQ-001 Parameter NREQ, default 3, meaning number of hardware write requesters (feedback, coins, motion engine).
REQ-002 Parameter STARVE_MAX, default 4, meaning maximum consecutive Avalon grants while any hardware request is pending.
REQ-003 CLK  input  1  system clock, 50 MHz, shared with VGA.
REQ-004 RESET  input  1  reset, asynchronous, active-low.
REQ-005 AVL_CS, AVL_WRITE  input  1 each  Avalon-MM slave select and write strobe.
REQ-006 AVL_ADDR  input  12  Avalon word address; only bit 11 = 1 (attribute bank) is arbitrated.
REQ-007 AVL_WRITEDATA  input  32  Avalon write data.
REQ-008 AVL_WAITREQUEST  output  1  stalls an attribute-bank Avalon write that is not granted this cycle.
REQ-009 hw_req  input  NREQ  per-requester write request, held high until granted.
REQ-010 hw_addr  input  NREQ x 12  per-requester word address.
REQ-011 hw_data  input  NREQ x 32  per-requester write data.
REQ-012 hw_gnt  output  NREQ  one-hot grant, combinational, same cycle as acceptance.
REQ-013 reg_we  output  1  registered write enable to attribute bank.
REQ-014 reg_addr  output  12  registered write address.
REQ-015 reg_wdata  output  32  registered write data.
REQ-016 owner  output  2  registered owner of last write: 0 NONE, 1 AVL, 2 HW.
REQ-017 err_sticky  output  1  set on any hardware request with address bit 11 = 0.

Function
REQ-018 Avalon request valid = AVL_CS & AVL_WRITE & AVL_ADDR[11]; Avalon writes with AVL_ADDR[11] = 0 are ignored and never stalled.
REQ-019 At most one requester granted per cycle; hw_gnt zero whenever Avalon is granted.
REQ-020 Avalon wins by default; hardware wins instead when starve counter == STARVE_MAX and any hw_req is high.
REQ-021 Starve counter (3 bits, saturating at STARVE_MAX) increments on each Avalon grant while any hw_req is high; clears on a hardware grant or any cycle with no hw_req.
REQ-022 Hardware selection is round-robin: search starts at (last_hw + 1) mod NREQ; last_hw updates only on a hardware grant.
REQ-023 AVL_WAITREQUEST = Avalon request valid AND Avalon not granted.
REQ-024 Granted write appears on reg_we/reg_addr/reg_wdata exactly one cycle after grant; reg_we is a single-cycle pulse per grant.
REQ-025 Back-to-back grants on consecutive cycles SHALL produce consecutive reg_we pulses with no bubble.
REQ-026 Hardware request with hw_addr[11] = 0 is granted but produces no reg_we; err_sticky sets next cycle.
REQ-027 No request valid: reg_we = 0, owner = NONE, reg_addr/reg_wdata hold previous values.
REQ-028 Requester dropping hw_req before grant is legal; request is simply forgotten.

Reset
REQ-029 RESET low asynchronously clears reg_we, reg_addr, reg_wdata, owner, err_sticky, starve counter to 0 and last_hw to NREQ-1.
REQ-030 While RESET low, hw_gnt = 0 and AVL_WAITREQUEST = 0; a grant in flight at reset assertion is discarded.
REQ-031 First grant after reset release SHALL occur no earlier than the first rising CLK edge with RESET high.

Structure
REQ-032 Package arb_pkg holds NREQ, STARVE_MAX defaults, ATTR_BANK_BIT = 11, and owner_t enum {OWN_NONE, OWN_AVL, OWN_HW}.
REQ-033 One sub-module rr_pick (NREQ-wide request vector, last index in; one-hot grant and index out, purely combinational).

Verification
REQ-034 Avalon write alone, addr 0x808, data 0xDEADBEEF -> AVL_WAITREQUEST 0, next cycle reg_we 1, reg_addr 0x808, reg_wdata 0xDEADBEEF, owner AVL.
REQ-035 hw_req = 3'b111 held, no Avalon -> grants in order 1, 2, 0, 1 on consecutive cycles, four consecutive reg_we pulses.
REQ-036 Continuous Avalon writes plus hw_req[0] held -> four Avalon grants, fifth cycle hw_gnt[0] = 1 with AVL_WAITREQUEST = 1, then Avalon resumes.
REQ-037 hw_req[2] with hw_addr 0x010 -> hw_gnt[2] = 1, no reg_we, err_sticky 1 next cycle, remains 1 until reset.
REQ-038 Avalon write to addr 0x100 with hw_req[1] -> no stall, hw_gnt[1] granted same cycle.
REQ-039 RESET asserted mid-burst (hw_req 3'b111) -> outputs cleared immediately; after release first grant goes to requester 0.
